// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
//   Inverse AES-128 key expansion. Loads the last round key (round NR) and
//   walks the schedule backwards, presenting round keys NR, NR-1, ..., 0 on a
//   valid/ready stream so the decryption datapath never stores all 11 keys.
//
// Ports
//   clk        in   1        clock, all state on rising edge
//   reset      in   1        asynchronous, active-low reset
//   start      in   1        begin a new schedule (sampled only when idle)
//   key_in     in   KEY_LEN  round-NR key, w0=[127:96] .. w3=[31:0]
//   key_ready  in   1        downstream accepts key_out this cycle
//   key_valid  out  1        key_out/round_out hold a valid round key
//   key_out    out  KEY_LEN  current round key, same word order as key_in
//   round_out  out  4        round index of key_out
//   busy       out  1        high whenever a schedule is in progress
//   done       out  1        one-cycle pulse after the round-0 key is taken
//
// inv_key_sub_bytes (helper)
//   Registered byte-wise forward AES S-box over DATA_LEN bits, 1-cycle latency.
// ---------------------------------------------------------------------------

module inv_key_sub_bytes #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] data_i,
    output logic [DATA_LEN-1:0] data_o
);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        logic [10:0] base;
        base = 11'd2040 - {x, 3'b000};
        return SBOX[base +: 8];
    endfunction

    logic [DATA_LEN-1:0] sub_s;
    logic [DATA_LEN-1:0] data_q;

    for (genvar i = 0; i < DATA_LEN / 8; i++) begin : g_byte
        assign sub_s[8*i +: 8] = sbox_lookup(data_i[8*i +: 8]);
    end

    // Substituted word register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= sub_s;
        end
    end

    assign data_o = data_q;

endmodule

module inv_key_schedule #(
    parameter int KEY_LEN  = 128,
    parameter int WORD_LEN = 32,
    parameter int NR       = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_ready,
    output logic               key_valid,
    output logic [KEY_LEN-1:0] key_out,
    output logic [3:0]         round_out,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EMIT = 3'd1,
        S_SUB  = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t               state_q, state_d;
    logic [KEY_LEN-1:0]   key_q, key_d;
    logic [3:0]           round_q, round_d;
    logic                 key_valid_q, busy_q, done_q;

    logic [WORD_LEN-1:0]  w0_s, w1_s, w2_s, w3_s;
    logic [WORD_LEN-1:0]  p0_s, p1_s, p2_s, p3_s;
    logic [WORD_LEN-1:0]  rot_s, sub_s;

    assign w0_s = key_q[127:96];
    assign w1_s = key_q[95:64];
    assign w2_s = key_q[63:32];
    assign w3_s = key_q[31:0];

    // Previous round's w3 is recoverable from the current key alone, so the
    // S-box can be fed during SUB and its registered result used in UPD.
    assign p3_s  = w3_s ^ w2_s;
    assign p2_s  = w2_s ^ w1_s;
    assign p1_s  = w1_s ^ w0_s;
    assign rot_s = {p3_s[23:0], p3_s[31:24]};
    assign p0_s  = w0_s ^ sub_s ^ {rcon(round_q), 24'h000000};

    inv_key_sub_bytes #(
        .DATA_LEN (WORD_LEN)
    ) u_sub_word (
        .clk    (clk),
        .reset  (reset),
        .data_i (rot_s),
        .data_o (sub_s)
    );

    // Next-state, key and round update
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = NR_L;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                if (key_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SUB;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_SUB: begin
                state_d = S_UPD;
            end
            S_UPD: begin
                key_d   = {p0_s, p1_s, p2_s, p3_s};
                round_d = round_q - 4'd1;
                state_d = S_EMIT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            round_q     <= 4'd0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            round_q     <= round_d;
            key_valid_q <= (state_d == S_EMIT);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign key_valid = key_valid_q;
    assign key_out   = key_q;
    assign round_out = round_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_inv_key_schedule
//   Directed bench for inv_key_schedule. Expected round keys come from a
//   forward AES-128 key expansion model whose S-box is derived from GF(2^8)
//   inversion plus the affine map, and from the FIPS-197 A.1 constants.
// ---------------------------------------------------------------------------
module tb_inv_key_schedule;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         busy;
    logic         done;

    inv_key_schedule #(.KEY_LEN(128), .WORD_LEN(32), .NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_out (round_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           rnd;
        logic [127:0] key;
    } vec_t;
    vec_t tbl [4];

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got_key [$];
    int           got_round [$];
    int           first_cyc [16];
    int           acc_cyc [16];
    int           done_cyc;
    int           t0;
    logic         busy_after;
    logic         valid_after;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128 key expansion into exp_rk[0..10]
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        w0 = k0[127:96]; w1 = k0[95:64]; w2 = k0[63:32]; w3 = k0[31:0];
        exp_rk[0] = k0;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            t = {w3[23:0], w3[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t = t ^ {rc, 24'h000000};
            w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
            exp_rk[r] = {w0, w1, w2, w3};
            rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
        end
    endtask

    // One full schedule; optional stall at round 7 and stray start at round 5
    task automatic run_sched(input logic [127:0] k, input int stall_n, input bit poke,
                             input logic [127:0] alt);
        int           stalled, guard;
        bit           poked, fin, hold, vprev;
        logic [127:0] hk;
        logic [3:0]   hr;
        got_key.delete();
        got_round.delete();
        for (int i = 0; i < 16; i++) begin first_cyc[i] = -1; acc_cyc[i] = -1; end
        done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; key_in = k; key_ready = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; key_in = ~k;
        stalled = 0; guard = 0; poked = 1'b0; fin = 1'b0; hold = 1'b0; vprev = 1'b0;
        hk = '0; hr = 4'd0;
        while (!fin && guard < 200) begin
            if (hold) begin
                chk("hold_valid", {127'd0, key_valid}, 128'd1);
                chk("hold_key", key_out, hk);
                chk("hold_round", {124'd0, round_out}, {124'd0, hr});
            end
            if (key_valid && !vprev) first_cyc[round_out] = cyc;
            vprev = key_valid;
            if (done) begin done_cyc = cyc; fin = 1'b1; end
            key_ready = 1'b1;
            start = 1'b0;
            if (stall_n > 0 && key_valid && round_out == 4'd7 && stalled < stall_n) begin
                key_ready = 1'b0;
                stalled++;
            end
            if (poke && !poked && key_valid && round_out == 4'd5) begin
                start = 1'b1; key_in = alt; poked = 1'b1;
            end
            hold = key_valid && !key_ready;
            hk = key_out; hr = round_out;
            if (key_valid && key_ready) begin
                got_key.push_back(key_out);
                got_round.push_back(int'(round_out));
                acc_cyc[round_out] = cyc;
            end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        chk("sched_finished", {127'd0, fin}, 128'd1);
        busy_after  = busy;
        valid_after = key_valid;
    endtask

    task automatic check_keys(input string tag);
        chk({tag, "_count"}, 128'(got_key.size()), 128'd11);
        for (int i = 0; i < got_key.size() && i < 11; i++) begin
            chk({tag, "_round"}, 128'(got_round[i]), 128'(10 - i));
            chk({tag, "_key"}, got_key[i], exp_rk[10 - i]);
        end
        chk({tag, "_idle_after"}, {126'd0, busy_after, valid_after}, 128'd0);
    endtask

    initial begin
        tbl[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[3] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        reset = 1'b0; start = 1'b0; key_in = '0; key_ready = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {key_valid, busy, done, round_out, key_out}, '0);
        reset = 1'b1;

        // FIPS-197 A.1 sequence with key_ready high, plus timing
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_sched(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 1'b0, '0);
        check_keys("a1");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a1_tbl_r%0d", tbl[i].rnd),
                (got_key.size() == 11) ? got_key[10 - tbl[i].rnd] : '0, tbl[i].key);
        end
        for (int i = 0; i <= 10; i++)
            chk($sformatf("t_valid_r%0d", 10 - i), 128'(first_cyc[10 - i]), 128'(t0 + 1 + 3 * i));
        chk("t_done", 128'(done_cyc), 128'(t0 + 32));
        chk("t_busy_low_cyc", 128'(cyc), 128'(t0 + 33));

        // Backpressure at round 7
        run_sched(exp_rk[10], 5, 1'b0, '0);
        check_keys("bp");
        chk("bp_stall_len", 128'(acc_cyc[7] - first_cyc[7]), 128'd5);
        chk("bp_next_valid", 128'(first_cyc[6]), 128'(acc_cyc[7] + 3));

        // Stray start with another key during round 5
        run_sched(exp_rk[10], 0, 1'b1, 128'h00112233445566778899aabbccddeeff);
        check_keys("ign");
        for (int i = 0; i < 4; i++) begin
            chk("ign_stays_idle", {126'd0, key_valid, busy}, 128'd0);
            @(posedge clk); #1;
        end

        // Reset during SUB of round 4, then restart
        begin
            int guard;
            @(posedge clk); #1;
            start = 1'b1; key_in = exp_rk[10]; key_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            guard = 0;
            while (!(key_valid && round_out == 4'd4) && guard < 60) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("rst_reach_r4", {123'd0, key_valid, round_out}, {123'd0, 1'b1, 4'd4});
            @(posedge clk); #1;
            chk("rst_in_sub", {126'd0, busy, key_valid}, 128'd2);
            reset = 1'b0;
            #1;
            chk("rst_mid_outputs", {key_valid, busy, done, round_out, key_out}, '0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
        end
        run_sched(exp_rk[10], 0, 1'b0, '0);
        check_keys("rst");

        // Round-trip with random keys
        for (int n = 0; n < 3; n++) begin
            expand({$urandom(), $urandom(), $urandom(), $urandom()});
            run_sched(exp_rk[10], (n == 1) ? 2 : 0, 1'b0, '0);
            check_keys($sformatf("rt%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
